ldst_control: RTL
=================

LDST_CONTROL -- requirements
Module: ldst_control

Interface
REQ-001 Parameter IR_W, default 32, instruction register width.
REQ-002 Parameter OPC_LSB, default 27, LSB of the 5-bit opcode field ir[31:27].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset; synchronous, active-high.
REQ-005 ir  input  IR_W  current IR register contents from the datapath.
REQ-006 PCout, Zlowout, MDRout, Rout, BAout, Cout  output  1 each  bus-driver enables.
REQ-007 MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn  output  1 each  register load enables.
REQ-008 Gra, Grb  output  1 each  register-field select for the select/encode logic.
REQ-009 IncPC, add  output  1 each  ALU operation selects.
REQ-010 read, write  output  1 each  memory strobes.
REQ-011 run  output  1  high while fetching or executing; low in HALT.
REQ-012 unsup  output  1  one-cycle pulse when an unsupported opcode is retired as a no-op.

Function
REQ-013 Moore FSM, one T-state per clk cycle; outputs decoded from the registered state only; unlisted outputs are 0.
REQ-014 Fetch: T0 = PCout, MARIn, IncPC, ZIn; T1 = Zlowout, PCIn, read, MDRIn; T2 = MDRout, IRIn.
REQ-015 Opcode is sampled from ir in T3; IR is valid because IRIn was asserted in T2.
REQ-016 ld (00000): T3 = Grb, BAout, YIn; T4 = Cout, add, ZIn; T5 = Zlowout, MARIn; T6 = read, MDRIn; T7 = MDRout, Gra, RIn; then T0.
REQ-017 ldi (00001): T3 to T4 as ld; T5 = Zlowout, Gra, RIn; then T0.
REQ-018 st (00010): T3 to T5 as ld; T6 = Gra, Rout, MDRIn with read=0; T7 = write; then T0.
REQ-019 read and write are never asserted in the same cycle; MDRIn with read=0 loads MDR from the bus.
REQ-020 nop (11010): T3 asserts no outputs and returns to T0.
REQ-021 halt (11011): T3 goes to HALT; HALT asserts no outputs, run=0, and stays there until clr.
REQ-022 Any other opcode behaves as nop and asserts unsup in T3 only.
REQ-023 Instruction latency: ld 8, st 8, ldi 6, nop/unsup 4 cycles from T0 to T0.
REQ-024 Only one T-state is active per cycle; no state skips or repeats occur except HALT.

Reset
REQ-025 clr=1 at a rising edge forces state RESET, regardless of the current state, including mid-T6 of st.
REQ-026 In RESET every output is 0, including run.
REQ-027 The first rising edge with clr=0 moves RESET to T0; run=1 from T0 onward.
REQ-028 A write in progress is abandoned by reset; no partial write occurs after RESET is entered.

Structure
REQ-029 Package cpu_pkg holds the 5-bit opcode constants (LD, LDI, ST, NOP, HALT) and the state encoding (RESET, T0 to T7, HALT).
REQ-030 Sub-module ctrl_decode maps the opcode to one-hot class flags {is_ld, is_ldi, is_st, is_nop, is_halt, is_unsup}.
REQ-031 The top-level module contains only the state register, the next-state logic and the output decode.

Verification
REQ-032 clr high 2 cycles, then low, with ir[31:27]=00000: T0 to T7 control sets exactly per REQ-014/016, and the next T0 occurs 8 cycles after the first.
REQ-033 ir[31:27]=00001: T5 = {Zlowout, Gra, RIn}; T0 follows in cycle 6; read never asserted after T1.
REQ-034 ir[31:27]=00010: T6 = {Gra, Rout, MDRIn} with read=0; T7 write=1 for exactly 1 cycle; read&write never both 1.
REQ-035 ir[31:27]=10101: unsup=1 in T3 only; T0 follows; no register or memory enable is asserted in T3.
REQ-036 ir[31:27]=11011: run falls after T3 and stays 0 for 20 cycles; clr pulse restores run=1 at T0.
REQ-037 Running st, clr asserted in T6: next cycle all outputs 0; write never pulses; the restart fetch begins at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Opcode constants, T-state encoding and opcode class flags
//                shared by the load/store control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_e;

  typedef struct packed {
    logic is_ld;
    logic is_ldi;
    logic is_st;
    logic is_nop;
    logic is_halt;
    logic is_unsup;
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Maps the 5-bit opcode to one-hot instruction class flags.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OPC_LD:   op_class.is_ld    = 1'b1;
      OPC_LDI:  op_class.is_ldi   = 1'b1;
      OPC_ST:   op_class.is_st    = 1'b1;
      OPC_NOP:  op_class.is_nop   = 1'b1;
      OPC_HALT: op_class.is_halt  = 1'b1;
      default:  op_class.is_unsup = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ldst_control.sv
`default_nettype none
// ============================================================================
//  Module      : ldst_control
//  Description : T-state sequencer for fetch plus ld / ldi / st / nop / halt.
//  Revision    : 1.0  initial release
// ============================================================================
module ldst_control
  import cpu_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int OPC_LSB = 27
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [IR_W-1:0] ir,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            MARIn,
  output logic            PCIn,
  output logic            MDRIn,
  output logic            IRIn,
  output logic            YIn,
  output logic            ZIn,
  output logic            RIn,
  output logic            Gra,
  output logic            Grb,
  output logic            IncPC,
  output logic            add,
  output logic            read,
  output logic            write,
  output logic            run,
  output logic            unsup
);

  state_e    state_q, state_d;
  logic      is_ldi_q, is_ldi_d;
  logic      is_st_q, is_st_d;
  op_class_t w_class;
  logic      w_mem_op;
  logic      w_unused_bits;

  ctrl_decode u_decode (
    .opcode   (ir[OPC_LSB +: 5]),
    .op_class (w_class)
  );

  assign w_mem_op      = w_class.is_ld | w_class.is_ldi | w_class.is_st;
  assign w_unused_bits = ^ir ^ w_class.is_nop;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_RESET;
      is_ldi_q <= 1'b0;
      is_st_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_ldi_q <= is_ldi_d;
      is_st_q  <= is_st_d;
    end
  end

  // IR is only valid from T3 on, so the class needed by T5..T7 is captured there.
  always_comb begin
    state_d  = state_q;
    is_ldi_d = is_ldi_q;
    is_st_d  = is_st_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        is_ldi_d = w_class.is_ldi;
        is_st_d  = w_class.is_st;
        if (w_mem_op)              state_d = S_T4;
        else if (w_class.is_halt)  state_d = S_HALT;
        else                       state_d = S_T0;
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = is_ldi_q ? S_T0 : S_T6;
      S_T6:    state_d = S_T7;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    MARIn   = 1'b0;
    PCIn    = 1'b0;
    MDRIn   = 1'b0;
    IRIn    = 1'b0;
    YIn     = 1'b0;
    ZIn     = 1'b0;
    RIn     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    IncPC   = 1'b0;
    add     = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    unsup   = 1'b0;
    run     = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1; MDRIn = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRIn = 1'b1; end
      S_T3: begin
        Grb   = w_mem_op;
        BAout = w_mem_op;
        YIn   = w_mem_op;
        unsup = w_class.is_unsup;
      end
      S_T4: begin Cout = 1'b1; add = 1'b1; ZIn = 1'b1; end
      S_T5: begin
        Zlowout = 1'b1;
        MARIn   = ~is_ldi_q;
        Gra     = is_ldi_q;
        RIn     = is_ldi_q;
      end
      // st drives the register onto the bus into MDR; ld pulls MDR from memory.
      S_T6: begin
        MDRIn = 1'b1;
        read  = ~is_st_q;
        Gra   = is_st_q;
        Rout  = is_st_q;
      end
      S_T7: begin
        write  = is_st_q;
        MDRout = ~is_st_q;
        Gra    = ~is_st_q;
        RIn    = ~is_st_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
